// File: rtl/rose_req_arbiter_pkg.sv
// rose_arb_pkg: shared state type and round-robin pick helper for rose_req_arbiter
package rose_arb_pkg;
  localparam int MAX_REQ = 16;
  typedef enum logic [0:0] {IDLE, BUSY} arb_state_t;
  // first set bit of pend at or after ptr, wrapping at n-1 -> 0
  function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] pend, input logic [3:0] ptr, input int n);
    logic [3:0] win;
    logic found;
    int idx;
    win = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = int'(ptr) + k;
      idx = idx >= n ? idx - n : idx;
      if (k < n && !found && pend[idx]) begin
        win = 4'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction
endpackage

// File: rtl/rose_req_arbiter_if.sv
// rose_req_arbiter_if: request/grant bundle between requesters and rose_req_arbiter
interface rose_req_arbiter_if #(parameter int N_REQ = 4, parameter int ID_W = $clog2(N_REQ));
  logic [N_REQ-1:0] req, gnt, pending;
  logic res_done, gnt_valid, overflow, timeout;
  logic [ID_W-1:0] gnt_id;
  modport master (output req, res_done, input gnt, gnt_valid, gnt_id, pending, overflow, timeout);
  modport slave (input req, res_done, output gnt, gnt_valid, gnt_id, pending, overflow, timeout);
endinterface

// File: rtl/rose_req_arbiter_rise_detect.sv
// rise_detect: per-bit rising-edge detector against the previous sampled value
module rise_detect #(parameter int N = 4) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] rise
);
  logic [N-1:0] d_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) d_q <= '0;
    else d_q <= d;
  assign rise = d & ~d_q;
endmodule

// File: rtl/rose_req_arbiter.sv
// rose_req_arbiter: round-robin arbiter granting one resource per rising req edge
module rose_req_arbiter import rose_arb_pkg::*; #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input logic clk,
  input logic rst_n,
  rose_req_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT);
  arb_state_t state;
  logic [N_REQ-1:0] rise, pending, gnt, win_oh, clear_mask;
  logic [ID_W-1:0] rr_ptr, win, gnt_id;
  logic [CW-1:0] busy_cnt;
  logic start, last, rel, to, overflow, timeout;
  rise_detect #(.N(N_REQ)) u_rise (.clk(clk), .rst_n(rst_n), .d(bus.req), .rise(rise));
  assign win        = ID_W'(rr_pick(MAX_REQ'(pending), 4'(rr_ptr), N_REQ));
  assign win_oh     = N_REQ'(1) << win;
  assign start      = state == IDLE && |pending;
  assign clear_mask = start ? win_oh : '0;
  assign last       = busy_cnt == CW'(TIMEOUT - 1);
  assign rel        = state == BUSY && (bus.res_done || last);
  // res_done wins over a coincident timeout
  assign to         = state == BUSY && !bus.res_done && last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      pending  <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      rr_ptr   <= '0;
      busy_cnt <= '0;
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      pending  <= rise | (pending & ~clear_mask);
      overflow <= |(rise & pending & ~clear_mask);
      timeout  <= to;
      if (start) begin
        state    <= BUSY;
        gnt      <= win_oh;
        gnt_id   <= win;
        rr_ptr   <= win == ID_W'(N_REQ - 1) ? '0 : win + 1'b1;
        busy_cnt <= '0;
      end else if (rel) begin
        state  <= IDLE;
        gnt    <= '0;
        gnt_id <= '0;
      end else if (state == BUSY) busy_cnt <= busy_cnt + 1'b1;
    end
  assign bus.gnt       = gnt;
  assign bus.gnt_valid = |gnt;
  assign bus.gnt_id    = gnt_id;
  assign bus.pending   = pending;
  assign bus.overflow  = overflow;
  assign bus.timeout   = timeout;
endmodule
